systolic_controller: RTL and testbench

SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

---
 rtl/systolic_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_systolic_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_controller.sv
// ---------------------------------------------------------------------------
// systolic_controller
//
// Sequencing controller for an N x N systolic array. It loads N weight rows
// from a weight FIFO into the array, feeds N input rows from an input FIFO,
// waits out the pipeline drain latency, then pushes N result rows into an
// output FIFO and holds data_ready until the host acknowledges the results.
//
// Parameters
//   N          array dimension (rows/columns)
//   DRAIN_CYC  systolic pipeline drain latency in cycles (must be >= 1)
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous active-high reset
//   start_inference     single-cycle request to run one inference batch
//   load_weight         single-cycle request to load N weight rows
//   activation_mode     activation select, captured on an accepted start
//   weight_fifo_empty   weight FIFO empty flag
//   input_fifo_empty    input FIFO empty flag
//   out_fifo_full       output FIFO full flag
//   output_read         host has consumed the results (honoured in DONE only)
//   weight_pop          weight FIFO read strobe (combinational)
//   input_pop           input FIFO read strobe (combinational)
//   array_load_weight   array weight shift strobe, weight_pop delayed 1 cycle
//   array_input_valid   array input shift strobe, input_pop delayed 1 cycle
//   out_push            output FIFO write strobe (combinational)
//   act_mode_q          latched activation mode
//   design_busy         high in LOAD_W, FEED, DRAIN and OUTPUT
//   data_ready          high in DONE
//   device_busy_err     one-cycle pulse on a rejected request
//   weights_valid       a complete weight set is resident in the array
// ---------------------------------------------------------------------------
module systolic_controller #(
  parameter int N         = 8,
  parameter int DRAIN_CYC = 2 * N - 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_inference,
  input  logic       load_weight,
  input  logic [2:0] activation_mode,
  input  logic       weight_fifo_empty,
  input  logic       input_fifo_empty,
  input  logic       out_fifo_full,
  input  logic       output_read,
  output logic       weight_pop,
  output logic       input_pop,
  output logic       array_load_weight,
  output logic       array_input_valid,
  output logic       out_push,
  output logic [2:0] act_mode_q,
  output logic       design_busy,
  output logic       data_ready,
  output logic       device_busy_err,
  output logic       weights_valid
);

  // Row counter is wide enough to hold N itself so it can saturate there.
  localparam int CW = $clog2(N) + 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [2:0]    act_mode_d;
  logic          weights_valid_q, weights_valid_d;
  logic          wv_pend_q, wv_pend_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          array_load_weight_q, array_load_weight_d;
  logic          array_input_valid_q, array_input_valid_d;
  logic          request_any;

  // Saturating increment: the shared row counter never wraps past N.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign request_any = start_inference | load_weight;

  // Next-state and strobe logic. The pop/push strobes depend only on the
  // current state and the FIFO flags, so they can never fire against an
  // empty/full flag. Every registered output is computed from the next
  // state so it lines up with the state it describes.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    drain_cnt_d     = drain_cnt_q;
    act_mode_d      = act_mode_q;
    weights_valid_d = weights_valid_q;
    wv_pend_d       = 1'b0;
    err_d           = 1'b0;
    weight_pop      = 1'b0;
    input_pop       = 1'b0;
    out_push        = 1'b0;

    // The final weight pop sets wv_pend; weights_valid follows one cycle
    // later, i.e. one cycle after the final array_load_weight strobe.
    if (wv_pend_q) begin
      weights_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // load_weight has priority; a simultaneous start is silently dropped.
        if (load_weight) begin
          state_d         = LOAD_W;
          cnt_d           = '0;
          weights_valid_d = 1'b0;
        end else if (start_inference) begin
          if (weights_valid_q) begin
            state_d    = FEED;
            cnt_d      = '0;
            act_mode_d = activation_mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_W: begin
        err_d      = request_any;
        weight_pop = !weight_fifo_empty;
        if (weight_pop) begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            wv_pend_d = 1'b1;
          end
        end
      end

      FEED: begin
        err_d     = request_any;
        input_pop = !input_fifo_empty;
        if (input_pop) begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_LAST) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end

      DRAIN: begin
        err_d = request_any;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = OUTPUT;
          cnt_d   = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end

      OUTPUT: begin
        err_d    = request_any;
        out_push = !out_fifo_full;
        if (out_push) begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        err_d = request_any;
        if (output_read) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d              = (state_d != IDLE) && (state_d != DONE);
    ready_d             = (state_d == DONE);
    array_load_weight_d = weight_pop;
    array_input_valid_d = input_pop;
  end

  // State and output registers. Reset also drops any pending weights_valid,
  // so a load interrupted by reset is never reported as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      drain_cnt_q         <= '0;
      act_mode_q          <= 3'd0;
      weights_valid_q     <= 1'b0;
      wv_pend_q           <= 1'b0;
      err_q               <= 1'b0;
      busy_q              <= 1'b0;
      ready_q             <= 1'b0;
      array_load_weight_q <= 1'b0;
      array_input_valid_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      drain_cnt_q         <= drain_cnt_d;
      act_mode_q          <= act_mode_d;
      weights_valid_q     <= weights_valid_d;
      wv_pend_q           <= wv_pend_d;
      err_q               <= err_d;
      busy_q              <= busy_d;
      ready_q             <= ready_d;
      array_load_weight_q <= array_load_weight_d;
      array_input_valid_q <= array_input_valid_d;
    end
  end

  assign array_load_weight = array_load_weight_q;
  assign array_input_valid = array_input_valid_q;
  assign design_busy       = busy_q;
  assign data_ready        = ready_q;
  assign device_busy_err   = err_q;
  assign weights_valid     = weights_valid_q;

endmodule

// File: tb/tb_systolic_controller.sv
// ---------------------------------------------------------------------------
// tb_systolic_controller
//
// Self-checking bench for systolic_controller. Scenarios are described as
// operations (load weights, run an inference, reset mid-load) and judged by
// transaction-level expectations: N pops, N pushes, a drain gap of
// DRAIN_CYC cycles, strobes never against a full/empty flag, array strobes
// lagging their pop by one cycle, single-cycle error pulses.
// ---------------------------------------------------------------------------
module tb_systolic_controller;

  localparam int N         = 8;
  localparam int DRAIN_CYC = 2 * N - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_inference, load_weight, output_read;
  logic [2:0] activation_mode;
  logic       weight_fifo_empty, input_fifo_empty, out_fifo_full;
  logic       weight_pop, input_pop, array_load_weight, array_input_valid;
  logic       out_push, design_busy, data_ready, device_busy_err, weights_valid;
  logic [2:0] act_mode_q;

  int errors = 0;
  int checks = 0;

  // Transaction monitor state
  int cyc = 0;
  int wpops, ipops, pushes;
  int last_wpop_cyc, last_ipop_cyc, first_push_cyc, wv_rise_cyc;
  int wrun, wrun_max, err_pulses;
  int strobe_viol, lag_viol, busy_viol;
  logic prev_wpop = 1'b0, prev_ipop = 1'b0, err_prev = 1'b0, wv_prev = 1'b0;

  // Flag-driving modes applied every cycle
  bit rnd_w = 0, rnd_in = 0, rnd_out = 0, tog_in = 0, full_stall = 0;

  systolic_controller #(.N(N), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_inference   (start_inference),
    .load_weight       (load_weight),
    .activation_mode   (activation_mode),
    .weight_fifo_empty (weight_fifo_empty),
    .input_fifo_empty  (input_fifo_empty),
    .out_fifo_full     (out_fifo_full),
    .output_read       (output_read),
    .weight_pop        (weight_pop),
    .input_pop         (input_pop),
    .array_load_weight (array_load_weight),
    .array_input_valid (array_input_valid),
    .out_push          (out_push),
    .act_mode_q        (act_mode_q),
    .design_busy       (design_busy),
    .data_ready        (data_ready),
    .device_busy_err   (device_busy_err),
    .weights_valid     (weights_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Count one comparison and report it when the observed value is wrong
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearStats();
    wpops = 0; ipops = 0; pushes = 0;
    last_wpop_cyc = -1; last_ipop_cyc = -1; first_push_cyc = -1; wv_rise_cyc = -1;
    wrun = 0; wrun_max = 0; err_pulses = 0;
    strobe_viol = 0; lag_viol = 0; busy_viol = 0;
  endtask

  // One clock: request pulses drop 1 time unit after the edge, FIFO flags are
  // updated for the new cycle, and outputs are observed 4 units after the edge.
  task automatic step();
    bit rst_edge;
    @(posedge clk);
    rst_edge = rst;
    cyc++;
    #1;
    start_inference = 1'b0;
    load_weight     = 1'b0;
    output_read     = 1'b0;
    if (rnd_w)  weight_fifo_empty = ($urandom_range(0, 2) == 0);
    if (rnd_in) input_fifo_empty  = ($urandom_range(0, 2) == 0);
    if (tog_in) input_fifo_empty  = ~input_fifo_empty;
    if (rnd_out) out_fifo_full = (pushes > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (full_stall) out_fifo_full = (ipops == N) && (cyc - last_ipop_cyc <= DRAIN_CYC + 5);
    #3;
    if ((weight_pop && weight_fifo_empty) || (input_pop && input_fifo_empty) ||
        (out_push && out_fifo_full))
      strobe_viol++;
    if (!rst_edge && ((array_load_weight !== prev_wpop) || (array_input_valid !== prev_ipop)))
      lag_viol++;
    if ((weight_pop || input_pop || out_push) && !design_busy) busy_viol++;
    if (weight_pop) begin
      wpops++; last_wpop_cyc = cyc; wrun++;
      if (wrun > wrun_max) wrun_max = wrun;
    end else begin
      wrun = 0;
    end
    if (input_pop) begin ipops++; last_ipop_cyc = cyc; end
    if (out_push) begin
      if (pushes == 0) first_push_cyc = cyc;
      pushes++;
    end
    if (weights_valid && !wv_prev && wv_rise_cyc < 0) wv_rise_cyc = cyc;
    wv_prev = weights_valid;
    if (device_busy_err) begin
      err_pulses++;
      if (err_prev) strobe_viol++;
    end
    err_prev  = device_busy_err;
    prev_wpop = weight_pop;
    prev_ipop = input_pop;
  endtask

  task automatic applyStimulus(input logic st, input logic ld, input logic rd);
    start_inference = st;
    load_weight     = ld;
    output_read     = rd;
    step();
  endtask

  function automatic int resetVector();
    return int'({weight_pop, input_pop, array_load_weight, array_input_valid, out_push,
                 design_busy, data_ready, device_busy_err, weights_valid, act_mode_q});
  endfunction

  // Load a full weight set; optionally raise start_inference alongside the
  // load request, which must be dropped without an error.
  task automatic loadWeights(input string tag, input bit with_start, input bit check_run);
    clearStats();
    applyStimulus(with_start, 1'b1, 1'b0);
    checkOutput({tag, "_busy_entry"}, int'(design_busy), 1);
    checkOutput({tag, "_wv_cleared"}, int'(weights_valid), 0);
    for (int k = 0; k < 500 && !weights_valid; k++) step();
    checkOutput({tag, "_wv_set"}, int'(weights_valid), 1);
    checkOutput({tag, "_pops"}, wpops, N);
    if (check_run) checkOutput({tag, "_consecutive"}, wrun_max, N);
    checkOutput({tag, "_wv_delay"}, wv_rise_cyc - last_wpop_cyc, 2);
    checkOutput({tag, "_lag"}, lag_viol, 0);
    checkOutput({tag, "_flag_viol"}, strobe_viol, 0);
    checkOutput({tag, "_busy_viol"}, busy_viol, 0);
    checkOutput({tag, "_err"}, err_pulses, 0);
    checkOutput({tag, "_idle"}, int'(design_busy), 0);
  endtask

  // Run one inference. stray: 0 none, 1 start during DRAIN, 2 load during FEED.
  task automatic runInference(input string tag, input logic [2:0] mode, input int stray,
                              input int exp_gap);
    bit stray_sent = 0;
    clearStats();
    activation_mode = mode;
    applyStimulus(1'b1, 1'b0, 1'b0);
    activation_mode = ~mode;
    for (int k = 0; k < 2000 && !data_ready; k++) begin
      if (stray == 1 && !stray_sent && ipops == N && cyc - last_ipop_cyc == 4) begin
        start_inference = 1'b1; stray_sent = 1;
      end
      if (stray == 2 && !stray_sent && ipops == 1) begin
        load_weight = 1'b1; stray_sent = 1;
      end
      if (!stray_sent && $urandom_range(0, 7) == 0) output_read = 1'b1;
      step();
    end
    checkOutput({tag, "_ready"}, int'(data_ready), 1);
    checkOutput({tag, "_in_pops"}, ipops, N);
    checkOutput({tag, "_pushes"}, pushes, N);
    checkOutput({tag, "_drain_gap"}, first_push_cyc - last_ipop_cyc, exp_gap);
    checkOutput({tag, "_act_mode"}, int'(act_mode_q), int'(mode));
    checkOutput({tag, "_err_pulses"}, err_pulses, (stray != 0) ? 1 : 0);
    checkOutput({tag, "_flag_viol"}, strobe_viol, 0);
    checkOutput({tag, "_lag"}, lag_viol, 0);
    checkOutput({tag, "_busy_viol"}, busy_viol, 0);
    step();
    checkOutput({tag, "_ready_held"}, int'(data_ready), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_ready_clear"}, int'(data_ready), 0);
    checkOutput({tag, "_idle"}, int'(design_busy), 0);
    checkOutput({tag, "_wv_kept"}, int'(weights_valid), 1);
  endtask

  initial begin
    logic [2:0] mode;
    rst = 1'b1;
    start_inference = 1'b0; load_weight = 1'b0; output_read = 1'b0;
    activation_mode = 3'd0;
    weight_fifo_empty = 1'b0; input_fifo_empty = 1'b0; out_fifo_full = 1'b0;
    clearStats();

    // Reset values, with non-empty FIFOs so stray strobes would show
    repeat (3) step();
    checkOutput("reset_outputs", resetVector(), 0);
    rst = 1'b0;
    step();
    checkOutput("idle_outputs", resetVector(), 0);

    // Start without weights: one-cycle error, stays idle
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("nowt_err", int'(device_busy_err), 1);
    checkOutput("nowt_busy", int'(design_busy), 0);
    step();
    checkOutput("nowt_err_single", int'(device_busy_err), 0);
    checkOutput("nowt_still_idle", int'(design_busy), 0);
    checkOutput("nowt_no_pop", ipops, 0);

    // Deterministic weight load from a full FIFO
    loadWeights("wload", 1'b0, 1'b1);

    // Full inference, mode 3, with a stray start during DRAIN
    runInference("infer", 3'd3, 1, DRAIN_CYC + 1);

    // Input FIFO toggling empty, output FIFO full for 5 OUTPUT cycles
    tog_in = 1; full_stall = 1;
    runInference("stall", 3'd5, 0, DRAIN_CYC + 6);
    tog_in = 0; full_stall = 0;
    input_fifo_empty = 1'b0; out_fifo_full = 1'b0;

    // Simultaneous load + start in IDLE, random weight FIFO availability
    rnd_w = 1;
    loadWeights("loadstart", 1'b1, 1'b0);
    rnd_w = 0;
    weight_fifo_empty = 1'b0;

    // Reset after 3 weight pops
    clearStats();
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 50 && wpops < 3; k++) step();
    rst = 1'b1;
    step();
    checkOutput("midrst_outputs", resetVector(), 0);
    rst = 1'b0;
    repeat (3) step();
    checkOutput("midrst_wv", int'(weights_valid), 0);
    checkOutput("midrst_idle", int'(design_busy), 0);
    checkOutput("midrst_pops", wpops, 3);
    loadWeights("reload", 1'b0, 1'b1);

    // Randomized inferences with random flags and stray requests
    rnd_in = 1; rnd_out = 1;
    for (int i = 0; i < 6; i++) begin
      mode = 3'($urandom_range(0, 7));
      runInference($sformatf("rand%0d", i), mode, int'($urandom_range(0, 2)), DRAIN_CYC + 1);
    end
    rnd_in = 0; rnd_out = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
